// File: rtl/mux_pkg.sv
// Shared types and sizes for the 4-input round-robin stream multiplexer.
// The select type is reused for the priority pointer and the output select code.
package mux_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/rr_arbiter_4.sv
// Combinational rotate-priority encoder: scans req starting at ptr and
// returns the first requesting index, wrapping modulo four.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [N_IN-1:0] req,
  input  sel_t            ptr,
  output sel_t            gnt_idx,
  output logic            gnt_any
);

  sel_t idx;

  // Walk offsets from farthest to nearest so the nearest requester to ptr wins.
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    idx     = ptr;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx     = ptr + sel_t'(k);
      gnt_idx = req[idx] ? idx : gnt_idx;
      gnt_any = gnt_any | req[idx];
    end
  end

endmodule : rr_arbiter_4

// File: rtl/rr_stream_mux_4.sv
// Round-robin arbiter and registered 4:1 stream multiplexer with a one-entry
// output register; the grant is recomputed every cycle with no lock.
module rr_stream_mux_4
  import mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     in_valid,
  input  logic [N_IN*W-1:0]   in_data,
  output logic [N_IN-1:0]     in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output sel_t                out_sel
);

  sel_t            ptr;
  sel_t            gnt_idx;
  logic            gnt_any;
  logic            can_load;
  logic            load;
  logic            drain;
  logic [W-1:0]    sel_data;

  rr_arbiter_4 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Handshake: accept a new word when the register is empty or being drained.
  always_comb begin
    can_load = ~out_valid | out_ready;
    load     = can_load & gnt_any & ~rst;
    drain    = out_valid & out_ready;
    if (load) begin
      in_ready = 4'b0001 << gnt_idx;
    end else begin
      in_ready = 4'b0000;
    end
  end

  // Data steering for the granted stream.
  always_comb begin
    sel_data = '0;
    case (gnt_idx)
      2'd0:    sel_data = in_data[0*W +: W];
      2'd1:    sel_data = in_data[1*W +: W];
      2'd2:    sel_data = in_data[2*W +: W];
      2'd3:    sel_data = in_data[3*W +: W];
      default: sel_data = '0;
    endcase
  end

  // Output register and priority pointer; ptr moves only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + sel_t'(1);
    end else if (drain) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule : rr_stream_mux_4

// File: tb/tb_rr_stream_mux_4.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural queue-free reference of the arbitration rules.
module tb_rr_stream_mux_4;

  localparam int W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*W-1:0]  in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [1:0]      out_sel;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_sel;
  int          m_ptr;

  int seq[$];

  always #5 clk = ~clk;

  rr_stream_mux_4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First valid input at or after the pointer, -1 when nothing is valid.
  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // Called just after a negedge with inputs set: check, clock, update model.
  task automatic step();
    int         g;
    bit         can;
    logic [3:0] er;
    #1;
    g   = model_grant(in_valid);
    can = !m_valid || out_ready;
    er  = (!rst && can && g >= 0) ? 4'(1 << g) : 4'b0000;
    check_value("in_ready",  32'(in_ready),  32'(er));
    check_value("out_valid", 32'(out_valid), 32'(m_valid));
    check_value("out_data",  32'(out_data),  32'(m_data));
    check_value("out_sel",   32'(out_sel),   32'(m_sel));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (er != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_ptr   = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = {4'h4, 4'h3, 4'h2, 4'h1};
    out_ready = 1'b1;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;

    // 1. reset with every input valid
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_in_ready",  32'(in_ready),  32'h0);
    check_value("rst_out_valid", 32'(out_valid), 32'h0);
    check_value("rst_out_data",  32'(out_data),  32'h0);
    check_value("rst_out_sel",   32'(out_sel),   32'h0);
    step();
    rst = 1'b0;

    // 2. round robin over all four, one word per cycle
    seq.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seq.push_back(int'(out_sel));
    end
    check_value("rr_count", 32'(seq.size()), 32'd8);
    foreach (seq[i]) check_value("rr_seq", 32'(seq[i]), 32'(i % 4));

    // 3. skip and wrap with only inputs 1 and 3 valid
    do_reset();
    in_valid = 4'b1010;
    seq.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      seq.push_back(int'(out_sel));
      check_value("skip_data", 32'(out_data), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    foreach (seq[i]) check_value("skip_seq", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // 4. backpressure holds the word from input 2
    do_reset();
    in_data  = {4'h4, 4'hA, 4'h2, 4'h1};
    in_valid = 4'b0100;
    step();
    in_valid  = 4'hF;
    out_ready = 1'b0;
    repeat (5) step();
    check_value("bp_data", 32'(out_data), 32'hA);
    check_value("bp_sel",  32'(out_sel),  32'd2);
    out_ready = 1'b1;
    step();
    check_value("bp_next_sel",   32'(out_sel),   32'd3);
    check_value("bp_next_valid", 32'(out_valid), 32'd1);

    // 5. input 0 raises valid briefly while input 1 holds the turn
    do_reset();
    in_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0011;
    step();
    in_valid = 4'b0010;
    step();
    in_valid = 4'b0000;
    repeat (2) step();

    // 6. reset while a word is stalled
    in_valid = 4'b1000;
    step();
    out_ready = 1'b0;
    in_valid  = 4'hF;
    step();
    do_reset();
    #1;
    check_value("mrst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    check_value("mrst_first_sel", 32'(out_sel), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(49) == 0);
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rr_stream_mux_4
